// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler
//   Shares one 24-bit SPI DAC serialiser between four CV/oscillator channels.
//   Channel updates are latched as pending requests. A round-robin arbiter picks
//   one, formats the DAC command word and holds the send request until the
//   serialiser drops chip-select. A fixed gap follows every frame.
//
// Ports
//   clock_in     system clock
//   reset        asynchronous active-high reset
//   ch_value     four 16-bit channel values, channel n at [16n+15:16n]
//   ch_strobe    per-channel update request, value sampled in the same cycle
//   dac_data     command word {cmd, 2'b00, addr[1:0], value[15:0]}
//   dac_send     send request to the serialiser (high only while awaiting accept)
//   spi_cs_in    serialiser chip-select, low while a frame is in progress
//   busy         high whenever the scheduler is not idle
//   pending      per-channel pending flags
//   overrun      sticky, a strobe arrived while the channel was already pending
//   timeout_err  sticky, a send was not accepted in time
module dac_channel_scheduler #(
    parameter int unsigned NUM_CH         = 4,
    parameter logic [3:0]  DAC_CMD        = 4'h3,
    parameter int unsigned GAP_CYCLES     = 24,
    parameter int unsigned ACCEPT_TIMEOUT = 255
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic [16*NUM_CH-1:0]   ch_value,
    input  logic [NUM_CH-1:0]      ch_strobe,
    output logic [23:0]            dac_data,
    output logic                   dac_send,
    input  logic                   spi_cs_in,
    output logic                   busy,
    output logic [NUM_CH-1:0]      pending,
    output logic [NUM_CH-1:0]      overrun,
    output logic                   timeout_err
);

    // Address field is two bits wide; the channel count is fixed at four.
    localparam int unsigned CH_W    = 2;
    localparam int unsigned CNT_MAX = (GAP_CYCLES > ACCEPT_TIMEOUT) ? GAP_CYCLES : ACCEPT_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAccept,
        StWaitDone,
        StGap
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CH_W-1:0]     r_rr;
    logic [CH_W-1:0]     r_gnt;
    logic [15:0]         r_latch [NUM_CH];
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   w_pending_nxt;
    logic [NUM_CH-1:0]   r_overrun;
    logic                r_timeout_err;
    logic [23:0]         r_dac_data;

    logic                w_gnt_valid;
    logic [CH_W-1:0]     w_gnt_idx;
    logic                w_grant;
    logic                w_timeout;
    logic                w_gap_done;

    // Round-robin search starting at the pointer, wrapping 3 -> 0.
    always_comb begin
        logic [CH_W-1:0] w_cand;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = r_rr;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = r_rr + CH_W'(i);
            if (!w_gnt_valid && r_pending[w_cand]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    assign w_grant    = (r_state == StIdle) && w_gnt_valid;
    // Accept (cs low) wins over a timeout landing in the same cycle.
    assign w_timeout  = (r_state == StWaitAccept) && spi_cs_in &&
                        (r_cnt == CNT_W'(ACCEPT_TIMEOUT - 1));
    assign w_gap_done = (r_cnt == CNT_W'(GAP_CYCLES - 1));

    // FSM state register
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) w_state_nxt = StWaitAccept;
            end
            StWaitAccept: begin
                if (!spi_cs_in)     w_state_nxt = StWaitDone;
                else if (w_timeout) w_state_nxt = StGap;
            end
            StWaitDone: begin
                if (spi_cs_in) w_state_nxt = StGap;
            end
            StGap: begin
                if (w_gap_done) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        dac_send = (r_state == StWaitAccept);
        busy     = (r_state != StIdle);
    end

    // Per-state cycle counter: restarts on every state change, saturates otherwise.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Capture beats clear: a strobe in the grant cycle keeps the channel pending.
    always_comb begin
        logic [NUM_CH-1:0] w_clr;
        logic [NUM_CH-1:0] w_set;
        w_clr = '0;
        w_set = '0;
        if (w_grant)   w_clr[w_gnt_idx] = 1'b1;
        if (w_timeout) w_set[r_gnt]     = 1'b1;
        w_pending_nxt = (r_pending & ~w_clr) | w_set | ch_strobe;
    end

    // Request capture, grant bookkeeping and sticky flags
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_pending     <= '0;
            r_overrun     <= '0;
            r_timeout_err <= 1'b0;
            r_rr          <= '0;
            r_gnt         <= '0;
            r_dac_data    <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_latch[n] <= '0;
            end
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= r_overrun | (ch_strobe & r_pending);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            // Grant reads the latch before this cycle's strobe lands, so a
            // simultaneous update is sent on the next grant.
            if (w_grant) begin
                r_dac_data <= {DAC_CMD, 2'b00, w_gnt_idx, r_latch[w_gnt_idx]};
                r_gnt      <= w_gnt_idx;
                r_rr       <= w_gnt_idx + CH_W'(1);
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_strobe[n]) begin
                    r_latch[n] <= ch_value[16*n +: 16];
                end
            end
        end
    end

    assign dac_data    = r_dac_data;
    assign pending     = r_pending;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Bench for dac_channel_scheduler: directed stimulus, a scoreboard queue of
// expected command words and a monitor that checks each frame as it starts.
module tb_dac_channel_scheduler;

    localparam int GAP = 24;
    localparam int TO  = 255;

    logic        clock_in;
    logic        reset;
    logic [63:0] ch_value;
    logic [3:0]  ch_strobe;
    logic [23:0] dac_data;
    logic        dac_send;
    logic        spi_cs_in;
    logic        busy;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        timeout_err;

    int          n_tests;
    int          n_fail;
    int          cyc;
    bit          ser_en;
    logic [23:0] sb [$];

    dac_channel_scheduler dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .ch_value    (ch_value),
        .ch_strobe   (ch_strobe),
        .dac_data    (dac_data),
        .dac_send    (dac_send),
        .spi_cs_in   (spi_cs_in),
        .busy        (busy),
        .pending     (pending),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return spi_cs_in;
            1:       return dac_send;
            default: return (!busy && pending == 4'b0000);
        endcase
    endfunction

    // Bounded wait, checked on falling edges; expiry counts as a failure.
    task automatic wait_sig(input string name, input int sel, input logic lvl, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sig_sel(sel) === lvl) return;
            @(negedge clock_in);
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles, got %b, required %b",
                 name, budget, sig_sel(sel), lvl);
    endtask

    task automatic wait_send_rise(input string name);
        wait_sig(name, 1, 1'b0, 500);
        wait_sig(name, 1, 1'b1, 500);
    endtask

    task automatic set_val(input int n, input logic [15:0] v);
        ch_value[16*n +: 16] = v;
    endtask

    task automatic strobe(input logic [3:0] m);
        ch_strobe = m;
        @(negedge clock_in);
        ch_strobe = 4'b0000;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dac_data"},    32'(dac_data),    32'h0);
        check({tag, "_dac_send"},    32'(dac_send),    32'h0);
        check({tag, "_busy"},        32'(busy),        32'h0);
        check({tag, "_pending"},     32'(pending),     32'h0);
        check({tag, "_overrun"},     32'(overrun),     32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    // Serialiser model: accepts a send by dropping cs for ten cycles.
    initial begin
        spi_cs_in = 1'b1;
        forever begin
            @(negedge clock_in);
            if (ser_en && !reset && dac_send && spi_cs_in) begin
                @(posedge clock_in);
                #1 spi_cs_in = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clock_in);
                    #1;
                    if (reset) break;
                end
                spi_cs_in = 1'b1;
            end
        end
    end

    // Monitor: every rising dac_send is a new frame; pop and compare.
    initial begin
        logic        prev_send;
        logic        prev_cs;
        logic [23:0] exp;
        int          t_cs;
        bit          t_cs_ok;
        prev_send = 1'b0;
        prev_cs   = 1'b1;
        t_cs      = 0;
        t_cs_ok   = 1'b0;
        cyc       = 0;
        forever begin
            @(negedge clock_in);
            cyc++;
            if (reset) begin
                prev_send = 1'b0;
                prev_cs   = 1'b1;
                t_cs_ok   = 1'b0;
            end else begin
                if (spi_cs_in && !prev_cs) begin
                    t_cs    = cyc;
                    t_cs_ok = 1'b1;
                end
                if (dac_send && !prev_send) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got dac_data 0x%06h, required no frame",
                                 dac_data);
                    end else begin
                        exp = sb.pop_front();
                        check("frame_data", 32'(dac_data), 32'(exp));
                    end
                    if (t_cs_ok) begin
                        n_tests++;
                        if (cyc - t_cs < GAP) begin
                            n_fail++;
                            $display("FAIL frame_gap: got %0d cycles, required at least %0d",
                                     cyc - t_cs, GAP);
                        end
                    end
                end
                prev_send = dac_send;
                prev_cs   = spi_cs_in;
            end
        end
    end

    initial begin
        logic [3:0] pw [4];
        int         cnt;
        pw[0] = 4'b1110;
        pw[1] = 4'b1100;
        pw[2] = 4'b1000;
        pw[3] = 4'b0000;
        n_tests   = 0;
        n_fail    = 0;
        ser_en    = 1'b1;
        reset     = 1'b1;
        ch_value  = '0;
        ch_strobe = 4'b0000;
        repeat (3) @(negedge clock_in);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock_in);

        // All four channels at once: served 0,1,2,3.
        set_val(0, 16'h1111);
        set_val(1, 16'h2222);
        set_val(2, 16'h3333);
        set_val(3, 16'h4444);
        sb.push_back(24'h301111);
        sb.push_back(24'h312222);
        sb.push_back(24'h323333);
        sb.push_back(24'h334444);
        strobe(4'b1111);
        check("all_pending_init", 32'(pending), 32'hF);
        for (int k = 0; k < 4; k++) begin
            wait_send_rise("all_send");
            check("all_pending_walk", 32'(pending), 32'(pw[k]));
        end
        wait_sig("all_quiet", 2, 1'b1, 1000);

        // Single request on channel 1.
        set_val(1, 16'hABCD);
        sb.push_back(24'h31ABCD);
        strobe(4'b0010);
        check("single_pending", 32'(pending), 32'h2);
        check("single_send_early", 32'(dac_send), 32'h0);
        @(negedge clock_in);
        check("single_send", 32'(dac_send), 32'h1);
        check("single_data", 32'(dac_data), 32'h31ABCD);
        check("single_pending_clr", 32'(pending), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        wait_sig("single_cs_low", 0, 1'b0, 100);
        check("single_send_held", 32'(dac_send), 32'h1);
        @(negedge clock_in);
        check("single_send_drop", 32'(dac_send), 32'h0);
        check("single_busy_done", 32'(busy), 32'h1);
        wait_sig("single_cs_high", 0, 1'b1, 100);
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clock_in);
        end
        n_tests++;
        if (cnt < GAP || cnt > GAP + 2) begin
            n_fail++;
            $display("FAIL single_gap_busy: got %0d busy cycles after cs high, required %0d..%0d",
                     cnt, GAP, GAP + 2);
        end

        // Fairness: ch2 request during ch0's frame beats ch0's repeat request.
        set_val(0, 16'h5555);
        sb.push_back(24'h305555);
        strobe(4'b0001);
        wait_sig("fair_cs_low", 0, 1'b0, 100);
        set_val(0, 16'h5A5A);
        set_val(2, 16'h6666);
        sb.push_back(24'h326666);
        sb.push_back(24'h305A5A);
        strobe(4'b0101);
        wait_send_rise("fair_send");
        check("fair_data", 32'(dac_data), 32'h326666);
        check("fair_pending", 32'(pending), 32'h1);
        wait_sig("fair_quiet", 2, 1'b1, 1000);

        // Overrun: two ch3 strobes while another frame is in flight.
        check("ovr_clear", 32'(overrun), 32'h0);
        set_val(1, 16'h7777);
        sb.push_back(24'h317777);
        strobe(4'b0010);
        wait_sig("ovr_cs_low", 0, 1'b0, 100);
        set_val(3, 16'h0100);
        strobe(4'b1000);
        set_val(3, 16'h0200);
        strobe(4'b1000);
        sb.push_back(24'h330200);
        check("ovr_flag", 32'(overrun), 32'h8);
        check("ovr_pending", 32'(pending), 32'h8);
        wait_sig("ovr_quiet", 2, 1'b1, 1000);
        check("ovr_sticky", 32'(overrun), 32'h8);

        // Timeout: serialiser never accepts, then recovers for the retry.
        ser_en = 1'b0;
        set_val(2, 16'h0ABC);
        sb.push_back(24'h320ABC);
        sb.push_back(24'h320ABC);
        strobe(4'b0100);
        wait_send_rise("to_send");
        cnt = 0;
        while (dac_send && cnt < 1000) begin
            cnt++;
            @(negedge clock_in);
        end
        check("to_send_len", 32'(cnt), 32'(TO));
        check("to_err", 32'(timeout_err), 32'h1);
        check("to_pending", 32'(pending), 32'h4);
        check("to_busy", 32'(busy), 32'h1);
        check("to_send_low", 32'(dac_send), 32'h0);
        ser_en = 1'b1;
        wait_sig("to_quiet", 2, 1'b1, 1000);
        check("to_err_sticky", 32'(timeout_err), 32'h1);

        // Reset while waiting for the frame to finish.
        set_val(1, 16'h1234);
        sb.push_back(24'h311234);
        strobe(4'b0010);
        wait_sig("rst_cs_low", 0, 1'b0, 100);
        @(negedge clock_in);
        check("rst_in_done_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        repeat (3) @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);
        set_val(3, 16'hBEEF);
        sb.push_back(24'h33BEEF);
        strobe(4'b1000);
        @(negedge clock_in);
        check("post_rst_send", 32'(dac_send), 32'h1);
        check("post_rst_data", 32'(dac_data), 32'h33BEEF);
        wait_sig("post_rst_quiet", 2, 1'b1, 1000);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
